// File: rtl/comp_arbiter.sv
// comp_arbiter: round-robin scheduler that shares one compression core
// among NUM_REQ input streams.
//
// A requester is granted for one burst of up to BURST_LEN words (or fewer
// if it raises req_last). Its words go straight through to the core. The
// arbiter then waits in DRAIN until the core pulses comp_dump, and only
// then rotates the round-robin pointer and arbitrates again.
//
// Optional feature (macro COMP_ARB_DRAIN_TIMEOUT_EN): a 13-bit drain
// watchdog. If comp_dump never arrives, it sets a sticky timeout_err after
// DRAIN_TIMEOUT cycles in DRAIN and returns to IDLE. Without the macro,
// DRAIN waits indefinitely and timeout_err is tied to 0.
//
// Ports:
//   clock, reset         clock (rising edge), async active-low reset
//   req_valid/last/data  per-requester word stream (data packed i*DATA_W)
//   req_ready            word accepted from requester i
//   comp_rdy, comp_dump  core ready, core flush-complete pulse
//   comp_data_in(_valid) word to the core (0 outside GRANT)
//   owner                current or last granted requester
//   busy                 high in GRANT or DRAIN
//   timeout_err          sticky drain-timeout flag
module comp_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int DATA_W        = 64,
  parameter int BURST_LEN     = 8,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      comp_rdy,
  input  logic                      comp_dump,
  output logic                      comp_data_in_valid,
  output logic [DATA_W-1:0]         comp_data_in,
  output logic [ID_W-1:0]           owner,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  // Elaboration-time parameter sanity; the drain counter is 13 bits wide.
  if (NUM_REQ < 2 || NUM_REQ > 4 || NUM_REQ > (1 << ID_W) || BURST_LEN < 1 ||
      DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 8192) begin : g_bad_params
    $error("comp_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_idx;
  logic              gnt_valid, gnt_last, xfer;
  logic [DATA_W-1:0] gnt_data;
  logic [ID_W-1:0]   next_ptr;

  // First asserted request scanning upward from rr_ptr, wrapping.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = ID_W'(idx);
      end
    end
  end

  assign gnt_valid = req_valid[grant_q];
  assign gnt_last  = req_last[grant_q];
  assign gnt_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign xfer      = (state_q == GRANT) && gnt_valid && comp_rdy;
  assign next_ptr  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef COMP_ARB_DRAIN_TIMEOUT_EN
  logic [12:0] drain_cnt_q, drain_cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    rr_ptr_d           = rr_ptr_q;
    beat_cnt_d         = beat_cnt_q;
    req_ready          = '0;
    comp_data_in_valid = 1'b0;
    comp_data_in       = '0;
`ifdef COMP_ARB_DRAIN_TIMEOUT_EN
    drain_cnt_d        = '0;
    err_d              = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        comp_data_in_valid = gnt_valid;
        comp_data_in       = gnt_data;
        req_ready[grant_q] = comp_rdy;
        // A stalled requester keeps the grant; only a transfer advances.
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (gnt_last || beat_cnt_q == CNT_W'(BURST_LEN - 1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (comp_dump) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
`ifdef COMP_ARB_DRAIN_TIMEOUT_EN
        // comp_dump wins over a same-cycle timeout.
        else if (drain_cnt_q == 13'(DRAIN_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef COMP_ARB_DRAIN_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
    end
  end
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // grant only changes on arbitration, so it doubles as the owner tag.
  assign owner = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_comp_arbiter.sv
module tb_comp_arbiter;
  localparam int NR = 4, IDW = 2, DW = 64, BL = 8, DT = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              comp_rdy, comp_dump, comp_data_in_valid, busy, timeout_err;
  logic [DW-1:0]     comp_data_in;
  logic [IDW-1:0]    owner;

  int n_chk = 0;
  int n_err = 0;

  comp_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW), .DATA_W(DW), .BURST_LEN(BL), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .comp_rdy(comp_rdy), .comp_dump(comp_dump),
    .comp_data_in_valid(comp_data_in_valid), .comp_data_in(comp_data_in),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int i, input logic [63:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic dump_to_idle();
    comp_dump = 1'b1;
    step();
    comp_dump = 1'b0;
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] w [3];
    logic [4:0]  pat;
    int          nx, widx;
    int          order [5];

    base  = 64'h0011223344556677;
    w[0]  = 64'hDEAD_0000_0000_0001;
    w[1]  = 64'hDEAD_0000_0000_0002;
    w[2]  = 64'hDEAD_0000_0000_0003;
    pat   = 5'b10101;
    order = '{0, 1, 2, 3, 0};

    // ---- reset held with every requester valid
    reset = 1'b0; req_valid = 4'hF; req_last = '0; req_data = '0;
    comp_rdy = 1'b1; comp_dump = 1'b0;
    step(); step();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(comp_data_in_valid), 64'h0);
    chk("rst_data", comp_data_in, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_terr", 64'(timeout_err), 64'h0);

    // ---- release: one cycle of arbitration, then req0 owns the core
    reset = 1'b1; req_last = 4'b0001; set_data(0, 64'hA5);
    step();
    chk("arb0_owner", 64'(owner), 64'h0);
    chk("arb0_ready", 64'(req_ready), 64'h1);
    chk("arb0_data", comp_data_in, 64'hA5);
    chk("arb0_busy", 64'(busy), 64'h1);
    step();
    req_valid = '0; req_last = '0;
    #1;
    chk("drain0_ready", 64'(req_ready), 64'h0);
    chk("drain0_valid", 64'(comp_data_in_valid), 64'h0);
    chk("drain0_data", comp_data_in, 64'h0);
    chk("drain0_busy", 64'(busy), 64'h1);
    dump_to_idle();
    chk("idle0_busy", 64'(busy), 64'h0);
    chk("idle0_owner", 64'(owner), 64'h0);

    // ---- burst cap: req1 streams without last, exactly BL transfers
    req_valid = 4'b0010;
    step();
    chk("burst_owner", 64'(owner), 64'h1);
    nx = 0;
    for (int c = 0; c < BL + 4; c++) begin
      set_data(1, base + 64'(nx));
      #1;
      if (req_ready[1]) begin
        chk("burst_data", comp_data_in, base + 64'(nx));
        nx++;
      end
      step();
    end
    chk("burst_count", 64'(nx), 64'(BL));
    chk("burst_drain_busy", 64'(busy), 64'h1);
    chk("burst_drain_data", comp_data_in, 64'h0);
    req_valid = '0;
    dump_to_idle();
    // rr_ptr is now 2: with 0,2,3 requesting, 2 must win
    req_valid = 4'b1101;
    step();
    chk("rr_after_burst", 64'(owner), 64'h2);

    // ---- early last with comp_rdy toggling 1,0,1,0,1
    req_valid = 4'b0100;
    widx = 0;
    for (int c = 0; c < 5; c++) begin
      comp_rdy = pat[c];
      set_data(2, w[widx]);
      req_last = (widx == 2) ? 4'b0100 : 4'b0000;
      #1;
      chk("bp_ready", 64'(req_ready), pat[c] ? 64'h4 : 64'h0);
      chk("bp_data", comp_data_in, w[widx]);
      step();
      if (pat[c]) widx++;
    end
    comp_rdy = 1'b1; req_last = '0;
    #1;
    chk("bp_drain_ready", 64'(req_ready), 64'h0);
    chk("bp_drain_busy", 64'(busy), 64'h1);
    req_valid = '0;
    dump_to_idle();

    // ---- reset during the 4th word of a burst (rr_ptr=3 -> req1 wins)
    req_valid = 4'b0010;
    step();
    chk("mid_owner", 64'(owner), 64'h1);
    step(); step(); step();
    chk("mid_ready4", 64'(req_ready), 64'h2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    chk("mid_rst_valid", 64'(comp_data_in_valid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_valid", 64'(comp_data_in_valid), 64'h0);

    // ---- fairness: all valid, single-word blocks, order 0,1,2,3,0
    req_valid = 4'hF; req_last = 4'hF; comp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_owner", 64'(owner), 64'(order[k]));
      chk("fair_ready", 64'(req_ready), 64'(1 << order[k]));
      step();
      chk("fair_drain", 64'(busy), 64'h1);
      step(); step(); step();
      dump_to_idle();
    end

    // ---- drain with comp_dump withheld (rr_ptr=1 -> req1 wins)
    step();
    chk("to_owner", 64'(owner), 64'h1);
    step();
    req_valid = '0;
`ifdef COMP_ARB_DRAIN_TIMEOUT_EN
    for (int c = 0; c < DT - 1; c++) step();
    chk("to_pre_err", 64'(timeout_err), 64'h0);
    chk("to_pre_busy", 64'(busy), 64'h1);
    step();
    chk("to_err", 64'(timeout_err), 64'h1);
    chk("to_idle", 64'(busy), 64'h0);
    req_valid = 4'hF;
    step();
    chk("to_next_owner", 64'(owner), 64'h2);
    chk("to_sticky", 64'(timeout_err), 64'h1);
`else
    for (int c = 0; c < DT + 4; c++) step();
    chk("nto_busy", 64'(busy), 64'h1);
    chk("nto_err", 64'(timeout_err), 64'h0);
    dump_to_idle();
    chk("nto_idle", 64'(busy), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/comp_arbiter.md
# comp_arbiter

Round-robin scheduler that shares one compression core among up to four input streams. Each requester presents 64-bit words with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and forwards its words to the core's `data_in`/`data_in_valid` inputs. It then holds the core until the core signals `dump` (block flushed) before rotating to the next requester. The block sits directly upstream of the compression top; `owner` tags which stream the current compressed output belongs to.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..4.
- `ID_W`, 2: owner tag width; `NUM_REQ <= 2**ID_W`.
- `DATA_W`, 64: word width.
- `BURST_LEN`, 8: maximum words per grant, ≥1.
- `DRAIN_TIMEOUT`, 4096: cycles to wait for `comp_dump` (macro builds only).

Ports:
- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  — requester word valid.
- `req_last`  in  NUM_REQ  — final word of requester's block.
- `req_data`  in  NUM_REQ*DATA_W  — requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  — word accepted from requester i.
- `comp_rdy`  in  1  — core can accept a word.
- `comp_dump`  in  1  — core flush complete, single-cycle pulse.
- `comp_data_in_valid`  out  1  — to core `data_in_valid`.
- `comp_data_in`  out  DATA_W  — to core `data_in`.
- `owner`  out  ID_W  — index of current or last granted requester.
- `busy`  out  1  — high in GRANT or DRAIN.
- `timeout_err`  out  1  — sticky drain-timeout flag.

## Operation
- States: IDLE, GRANT, DRAIN. Registers: `state`, `grant`, `rr_ptr`, `beat_cnt`, drain counter.
- **IDLE**
  - When any `req_valid` is high, select the first asserted index scanning from `rr_ptr` upward, wrapping mod NUM_REQ.
  - Register it into `grant` and `owner`, clear `beat_cnt`, go to GRANT.
  - Requests are sampled only in IDLE.
- **GRANT**
  - `comp_data_in_valid = req_valid[grant]` and `comp_data_in = req_data[grant]`, both combinational.
  - `req_ready[grant] = comp_rdy`; all other `req_ready` bits are 0.
  - Transfer occurs on `req_valid[grant] && comp_rdy`; each transfer increments `beat_cnt`.
  - A transfer with `req_last[grant]=1`, or with `beat_cnt==BURST_LEN-1`, moves the block to DRAIN.
  - If `req_valid[grant]` drops mid-burst, the grant is held; the block never aborts a burst.
  - `comp_dump` is ignored in GRANT.
- **DRAIN**
  - Outputs to the core are idle: valid 0, data 0; all `req_ready` are 0.
  - On `comp_dump`: set `rr_ptr <= (grant+1) mod NUM_REQ` and go to IDLE.
- Outside GRANT, `comp_data_in` is forced to 0.
- `owner` holds its value in IDLE until the next grant.

## Timing
- Reset values: `state`=IDLE; `grant`, `rr_ptr`, `owner`, `beat_cnt` = 0; `req_ready`=0, `comp_data_in_valid`=0, `comp_data_in`=0, `busy`=0, `timeout_err`=0.
- Reset asserted mid-burst aborts immediately. No word is forwarded after reset deasserts until a fresh arbitration.
- Arbitration latency: `req_valid` high in IDLE at cycle N → first `req_ready` possible at cycle N+1.
- Re-arbitration: `comp_dump` sampled at cycle M in DRAIN → IDLE at M+1 → next GRANT at M+2 at the earliest.
- Throughput in GRANT: one word per cycle while `comp_rdy` and `req_valid[grant]` are both high.
- `req_last` coinciding with `beat_cnt==BURST_LEN-1` produces a single transition to DRAIN.
- Wrap-around: `grant==NUM_REQ-1` → `rr_ptr`=0.

## Configuration
- `COMP_ARB_DRAIN_TIMEOUT_EN` defined:
  - A 13-bit drain counter runs in DRAIN.
  - If it reaches DRAIN_TIMEOUT-1 with no `comp_dump`, `timeout_err` is set (sticky until reset), `rr_ptr` rotates, and the state returns to IDLE.
  - `comp_dump` arriving in the same cycle as the timeout takes precedence, and no error is flagged.
- Undefined: no counter; DRAIN waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- **Reset:** hold `reset`=0 with all `req_valid`=1 → all outputs 0, no `req_ready`; release → grant goes to req0, `owner`=0.
- **Burst cap:** BURST_LEN=8, req1 streams words 0x0011223344556677+i with no `req_last`, `comp_rdy`=1 → exactly 8 transfers, then DRAIN; `comp_dump` → IDLE; `rr_ptr`=2.
- **Early last and backpressure:** req2 sends 3 words with `req_last` on the third; `comp_rdy` toggles 1,0,1,0,1 → 3 transfers only on `comp_rdy`=1 cycles, data order preserved, then DRAIN.
- **Fairness:** all four requesters continuously valid, each sending single-word `req_last` blocks; `comp_dump` 5 cycles after each last word → grant order 0,1,2,3,0.
- **Timeout (macro on):** DRAIN_TIMEOUT=16 with `comp_dump` withheld → `timeout_err` rises at the 16th DRAIN cycle and stays high; the next grant proceeds normally.
- **Reset mid-burst:** assert `reset` during the 4th word of a burst → `req_ready` and `comp_data_in_valid` drop asynchronously; `rr_ptr`=0 after release.
